// File: rtl/timer_pkg.sv
// Shared types and constants for the multi-channel timer.
// Channel state encoding and event-flag bit positions.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } chan_state_t;

  localparam int NFLG      = 3;
  localparam int FLG_OVER  = 0;
  localparam int FLG_UNDER = 1;
  localparam int FLG_CMP   = 2;

endpackage

// File: rtl/timer_chan.sv
// One timer channel: run FSM, up/down counter with reload,
// compare match, sticky W1C flags and wrap pulses.
module timer_chan
  import timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             en,
  input  logic             updown,
  input  logic             oneshot,
  input  logic             init_cnt,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic [NFLG-1:0]  flag_clr,
  output logic [WIDTH-1:0] cnt,
  output logic [NFLG-1:0]  flags,
  output logic             over_pls,
  output logic             under_pls,
  output logic             running
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  chan_state_t      state;
  logic [WIDTH-1:0] reload;
  logic             step;
  logic             wrap_up;
  logic             wrap_dn;
  logic             wrap;
  logic [WIDTH-1:0] nxt_cnt;
  logic [NFLG-1:0]  set_bits;

  // next count value and events for a step in this cycle
  always_comb begin
    step     = 1'b0;
    wrap_up  = 1'b0;
    wrap_dn  = 1'b0;
    wrap     = 1'b0;
    nxt_cnt  = cnt;
    set_bits = '0;
    step     = (state == RUN) && en && tick && !init_cnt;
    wrap_up  = updown && (cnt == MAX);
    wrap_dn  = !updown && (cnt == '0);
    wrap     = wrap_up || wrap_dn;
    if (wrap) begin
      nxt_cnt = reload;
    end else if (updown) begin
      nxt_cnt = cnt + ONE;
    end else begin
      nxt_cnt = cnt - ONE;
    end
    if (step) begin
      set_bits[FLG_OVER]  = wrap_up;
      set_bits[FLG_UNDER] = wrap_dn;
      set_bits[FLG_CMP]   = (nxt_cnt == cmp_val);
    end
  end

  // run-state machine; init overrides, one-shot parks in HALT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (init_cnt) begin
      state <= en ? RUN : IDLE;
    end else begin
      unique case (state)
        IDLE: if (en) state <= RUN;
        RUN: begin
          if (!en) begin
            state <= IDLE;
          end else if (step && wrap && oneshot) begin
            state <= HALT;
          end
        end
        HALT: if (!en) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // counter and reload register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      reload <= '0;
    end else if (init_cnt) begin
      cnt    <= load_val;
      reload <= load_val;
    end else if (step) begin
      cnt    <= nxt_cnt;
    end
  end

  // sticky flags: a set in the same cycle beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
    end else if (init_cnt) begin
      flags <= '0;
    end else begin
      flags <= (flags & ~flag_clr) | set_bits;
    end
  end

  // single-cycle wrap pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      over_pls  <= 1'b0;
      under_pls <= 1'b0;
    end else if (init_cnt) begin
      over_pls  <= 1'b0;
      under_pls <= 1'b0;
    end else begin
      over_pls  <= set_bits[FLG_OVER];
      under_pls <= set_bits[FLG_UNDER];
    end
  end

  assign running = (state == RUN);

endmodule

// File: rtl/timer_nch.sv
// NCH up/down timers sharing one prescaler tick,
// with a masked interrupt reduced over all channel flags.
module timer_nch
  import timer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int PRE_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PRE_W-1:0]     presc_div,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       updown,
  input  logic [NCH-1:0]       oneshot,
  input  logic [NCH-1:0]       init_cnt,
  input  logic [NCH*WIDTH-1:0] load_val,
  input  logic [NCH*WIDTH-1:0] cmp_val,
  input  logic [NCH*NFLG-1:0]  flag_clr,
  input  logic [NCH*NFLG-1:0]  irq_mask,
  output logic [NCH*WIDTH-1:0] cnt,
  output logic [NCH*NFLG-1:0]  flags,
  output logic [NCH-1:0]       over_pls,
  output logic [NCH-1:0]       under_pls,
  output logic [NCH-1:0]       running,
  output logic                 irq
);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  // >= lets a lowered divider take effect without waiting for a roll
  assign tick = (pre_cnt >= presc_div);

  // shared prescaler counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    timer_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .en       (en[g]),
      .updown   (updown[g]),
      .oneshot  (oneshot[g]),
      .init_cnt (init_cnt[g]),
      .load_val (load_val[g*WIDTH +: WIDTH]),
      .cmp_val  (cmp_val[g*WIDTH +: WIDTH]),
      .flag_clr (flag_clr[g*NFLG +: NFLG]),
      .cnt      (cnt[g*WIDTH +: WIDTH]),
      .flags    (flags[g*NFLG +: NFLG]),
      .over_pls (over_pls[g]),
      .under_pls(under_pls[g]),
      .running  (running[g])
    );
  end

  assign irq = |(flags & irq_mask);

endmodule

// File: tb/tb_timer_nch.sv
// Randomized scoreboard bench for timer_nch (WIDTH=8, NCH=2).
// Expected outputs come from an arithmetic model of the timer rules.
module tb_timer_nch;

  localparam int W = 8;
  localparam int N = 2;
  localparam int P = 8;
  localparam int MAXV = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [P-1:0]   presc_div;
  logic [N-1:0]   en, updown, oneshot, init_cnt;
  logic [N*W-1:0] load_val, cmp_val, cnt;
  logic [N*3-1:0] flag_clr, irq_mask, flags;
  logic [N-1:0]   over_pls, under_pls, running;
  logic           irq;

  timer_nch #(.WIDTH(W), .NCH(N), .PRE_W(P)) dut (
    .clk(clk), .rst(rst), .presc_div(presc_div), .en(en),
    .updown(updown), .oneshot(oneshot), .init_cnt(init_cnt),
    .load_val(load_val), .cmp_val(cmp_val), .flag_clr(flag_clr),
    .irq_mask(irq_mask), .cnt(cnt), .flags(flags),
    .over_pls(over_pls), .under_pls(under_pls),
    .running(running), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] cnt;
    logic [N*3-1:0] flags;
    logic [N-1:0]   ov;
    logic [N-1:0]   un;
    logic [N-1:0]   run;
    logic           irq;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // model: 0 stopped, 1 counting, 2 parked after one-shot wrap
  int       m_pre;
  int       m_cnt [N];
  int       m_rel [N];
  int       m_mode[N];
  bit [2:0] m_flg [N];
  bit       m_ov  [N];
  bit       m_un  [N];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pre = 0;
    for (int c = 0; c < N; c++) begin
      m_cnt[c] = 0; m_rel[c] = 0; m_mode[c] = 0;
      m_flg[c] = '0; m_ov[c] = 0; m_un[c] = 0;
    end
  endfunction

  function automatic void model_edge();
    bit tk;
    tk = (m_pre >= int'(presc_div));
    m_pre = tk ? 0 : m_pre + 1;
    for (int c = 0; c < N; c++) begin
      bit [2:0] set;
      bit       wrapped;
      set = '0;
      wrapped = 0;
      if (init_cnt[c]) begin
        m_cnt[c] = int'(load_val[c*W +: W]);
        m_rel[c] = m_cnt[c];
        m_flg[c] = '0;
        m_ov[c] = 0;
        m_un[c] = 0;
        m_mode[c] = en[c] ? 1 : 0;
        continue;
      end
      m_ov[c] = 0;
      m_un[c] = 0;
      if (m_mode[c] == 0) begin
        if (en[c]) m_mode[c] = 1;
      end else if (m_mode[c] == 2) begin
        if (!en[c]) m_mode[c] = 0;
      end else if (!en[c]) begin
        m_mode[c] = 0;
      end else if (tk) begin
        if (updown[c]) begin
          if (m_cnt[c] == MAXV) begin
            m_cnt[c] = m_rel[c]; set[0] = 1; m_ov[c] = 1; wrapped = 1;
          end else m_cnt[c] = m_cnt[c] + 1;
        end else begin
          if (m_cnt[c] == 0) begin
            m_cnt[c] = m_rel[c]; set[1] = 1; m_un[c] = 1; wrapped = 1;
          end else m_cnt[c] = m_cnt[c] - 1;
        end
        if (m_cnt[c] == int'(cmp_val[c*W +: W])) set[2] = 1;
        if (wrapped && oneshot[c]) m_mode[c] = 2;
      end
      m_flg[c] = (m_flg[c] & ~flag_clr[c*3 +: 3]) | set;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    for (int c = 0; c < N; c++) begin
      e.cnt[c*W +: W] = m_cnt[c][W-1:0];
      e.flags[c*3 +: 3] = m_flg[c];
      e.ov[c] = m_ov[c];
      e.un[c] = m_un[c];
      e.run[c] = (m_mode[c] == 1);
    end
    e.irq = |(e.flags & irq_mask);
    return e;
  endfunction

  // called at a negedge with inputs settled: predict next edge, advance
  task automatic tick_once();
    model_edge();
    sbq.push_back(model_out());
    @(negedge clk);
    init_cnt = '0;
    flag_clr = '0;
  endtask

  function automatic int pick_val();
    case ($urandom_range(0, 2))
      0: return int'($urandom_range(0, 3));
      1: return int'($urandom_range(252, 255));
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  exp_t me;
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      check("cnt", 64'(cnt), 64'(me.cnt));
      check("flags", 64'(flags), 64'(me.flags));
      check("over_pls", 64'(over_pls), 64'(me.ov));
      check("under_pls", 64'(under_pls), 64'(me.un));
      check("running", 64'(running), 64'(me.run));
      check("irq", 64'(irq), 64'(me.irq));
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_cnt"}, 64'(cnt), 64'd0);
    check({tag, "_flags"}, 64'(flags), 64'd0);
    check({tag, "_over"}, 64'(over_pls), 64'd0);
    check({tag, "_under"}, 64'(under_pls), 64'd0);
    check({tag, "_running"}, 64'(running), 64'd0);
    check({tag, "_irq"}, 64'(irq), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    presc_div = '0; en = '0; updown = '0; oneshot = '0;
    init_cnt = '0; load_val = '0; cmp_val = 16'h8080;
    flag_clr = '0; irq_mask = '0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // ch0 up from FD with prescaler off
    presc_div = 8'd0;
    updown[0] = 1'b1; en[0] = 1'b1;
    load_val[7:0] = 8'hFD; init_cnt[0] = 1'b1;
    tick_once();
    tick_once();
    check("up_fe", 64'(cnt[7:0]), 64'hFE);
    tick_once();
    check("up_ff", 64'(cnt[7:0]), 64'hFF);
    tick_once();
    check("up_wrap", 64'(cnt[7:0]), 64'hFD);
    check("up_ovp", 64'(over_pls[0]), 64'd1);
    check("up_oflag", 64'(flags[0]), 64'd1);
    tick_once();
    check("up_ovp_1cyc", 64'(over_pls[0]), 64'd0);

    // ch1 down from 02 with tick every 4 clocks
    en[0] = 1'b0;
    presc_div = 8'd3;
    updown[1] = 1'b0; en[1] = 1'b1;
    load_val[15:8] = 8'h02; init_cnt[1] = 1'b1;
    for (int i = 0; i < 16; i++) tick_once();

    // ch0 one-shot wrap then hold
    presc_div = 8'd0;
    oneshot[0] = 1'b1; en[0] = 1'b1;
    load_val[7:0] = 8'hFF; init_cnt[0] = 1'b1;
    tick_once();
    tick_once();
    check("os_running", 64'(running[0]), 64'd0);
    check("os_cnt", 64'(cnt[7:0]), 64'hFF);
    for (int i = 0; i < 20; i++) tick_once();
    check("os_hold", 64'(cnt[7:0]), 64'hFF);

    // compare match, then clear racing a new set
    oneshot[0] = 1'b0;
    cmp_val[7:0] = 8'h10;
    load_val[7:0] = 8'h0E; init_cnt[0] = 1'b1;
    tick_once();
    tick_once();
    check("cmp_early", 64'(flags[2]), 64'd0);
    tick_once();
    check("cmp_set", 64'(flags[2]), 64'd1);
    cmp_val[7:0] = 8'h11;
    flag_clr[2] = 1'b1;
    tick_once();
    check("cmp_set_wins", 64'(flags[2]), 64'd1);
    en = '0;
    flag_clr[2] = 1'b1;
    tick_once();
    check("cmp_cleared", 64'(flags[2]), 64'd0);

    // irq masking on ch1 under flag
    irq_mask = '0;
    tick_once();
    irq_mask = 6'b010_000;
    #1;
    check("irq_mask_on", 64'(irq), 64'(|(model_out().flags & irq_mask)));
    tick_once();
    flag_clr[4] = 1'b1;
    tick_once();
    check("irq_after_clr", 64'(irq), 64'd0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 49) == 0) presc_div = P'($urandom_range(0, 3));
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
        if ($urandom_range(0, 19) == 0) updown[c] = ~updown[c];
        if ($urandom_range(0, 29) == 0) oneshot[c] = ~oneshot[c];
        if ($urandom_range(0, 24) == 0) begin
          init_cnt[c] = 1'b1;
          load_val[c*W +: W] = W'(pick_val());
        end
        if ($urandom_range(0, 19) == 0) cmp_val[c*W +: W] = W'(pick_val());
      end
      if ($urandom_range(0, 5) == 0) flag_clr = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) irq_mask = 6'($urandom_range(0, 63));
      tick_once();
    end

    // async reset mid-count and mid-prescale
    presc_div = 8'd2;
    en = 2'b11; updown = 2'b01; oneshot = '0;
    load_val = 16'h1040; init_cnt = 2'b11;
    for (int i = 0; i < 7; i++) tick_once();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    en = '0;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) tick_once();
    check("post_rst_hold", 64'(cnt), 64'd0);
    en = 2'b11;
    for (int i = 0; i < 12; i++) tick_once();

    @(negedge clk);
    check("sb_drain", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
